hazard_tracker: RTL
===================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have parameter XZR, default 5'd31, meaning the zero register index; writes to it are never tracked.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall-event counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port id_valid  input  1  the decode stage holds a real instruction.
REQ-006 SHALL have port id_rd  input  5  destination register (Rd) of the decode instruction.
REQ-007 SHALL have port id_regwr  input  1  the decode instruction writes the register file.
REQ-008 SHALL have port id_memrd  input  1  the decode instruction is a load (result available only after MEM).
REQ-009 SHALL have port id_rn, id_rm  input  5 each  the source registers of the decode instruction.
REQ-010 SHALL have port id_use_rn, id_use_rm  input  1 each  the corresponding source is actually read.
REQ-011 SHALL have port flush  input  1  branch taken; squash the decode and EX slots.
REQ-012 SHALL have port dest_ex, dest_mem, dest_wb  output  5 each  Rd tracked in EX, MEM and WB.
REQ-013 SHALL have port regwr_ex, regwr_mem, regwr_wb  output  1 each  qualified write enables per stage.
REQ-014 SHALL have port stall  output  1  load-use hazard; decode and fetch hold.
REQ-015 SHALL have port stall_cnt  output  CNT_W  count of stall cycles, saturating.

Function
REQ-016 SHALL keep one tag per stage (EX, MEM, WB) containing valid, rd, regwr and memrd.
REQ-017 SHALL qualify the captured regwr as id_valid & id_regwr & (id_rd != XZR), so regwr_* is never 1 for rd 31.
REQ-018 SHALL assert stall combinationally when all of the following hold: EX valid, EX memrd, EX regwr, and for either source, id_use_x & (id_x == dest_ex) & (id_x != XZR) & id_valid.
REQ-019 SHALL, on each clock edge when no stall and no flush occur, shift the pipeline: WB<=MEM, MEM<=EX, EX<=decode tag.
REQ-020 SHALL, on a stall cycle, still shift WB<=MEM and MEM<=EX, and load a bubble (all fields 0) into EX; the decode inputs are re-presented next cycle.
REQ-021 SHALL, on a flush cycle, load a bubble into EX and also convert the current EX tag into a bubble before it moves to MEM, so MEM receives a bubble.
REQ-022 SHALL give flush priority over stall when both are asserted in the same cycle: flush behaviour applies and stall_cnt does not increment.
REQ-023 SHALL drive dest_* and regwr_* directly from registered stage tags, so outputs change only on the clock edge, and the EX tag feeds the forwarding unit.
REQ-024 SHALL force regwr_x to 0 whenever the corresponding stage's valid bit is 0; dest_x is then don't-care but SHALL be driven 0.
REQ-025 SHALL increment stall_cnt by 1 on each edge where stall=1 and flush=0, and SHALL hold it at all-ones once saturated (no wrap).
REQ-026 SHALL have zero-cycle latency for stall; the tag in EX is visible one cycle after capture and in WB three cycles after capture.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear all stage tags and stall_cnt; all dest_*=0, regwr_*=0, stall=0 (stall=0 follows from EX valid being 0).
REQ-028 SHALL, when reset is asserted mid-operation, discard all in-flight tags with no partial shift; the first edge after release captures the decode tag normally.

Structure
REQ-029 SHALL take the stage-tag struct (valid, rd[4:0], regwr, memrd), the BUBBLE constant and the XZR constant from the shared package pipe_pkg.
REQ-030 SHALL implement each stage as an instance of sub-module dest_stage, a tag register with async active-low clear, load enable and squash inputs; three instances are used.

Verification
REQ-031 SHALL be verified with this scenario: ADD rd=5 then SUB rn=5 -> next cycle dest_ex=5, regwr_ex=1, stall=0; two cycles later dest_mem=5.
REQ-032 SHALL be verified with this scenario: LDUR rd=7 followed by a decode with rn=7 and id_use_rn=1 -> stall=1 for exactly one cycle, EX shows a bubble (regwr_ex=0), and stall_cnt goes 0->1.
REQ-033 SHALL be verified with this scenario: LDUR rd=31 followed by a use of rn=31 -> stall=0 and regwr_ex=0.
REQ-034 SHALL be verified with this scenario: ADD rd=3 in EX with flush=1 -> next cycle regwr_mem=0 and regwr_ex=0.
REQ-035 SHALL be verified with this scenario: load-use stall with flush=1 in the same cycle -> stall_cnt unchanged and both EX and MEM hold bubbles.
REQ-036 SHALL be verified with this scenario: reset_n dropped mid-stream with 3 valid tags in flight -> all outputs are 0 immediately without waiting for a clock edge; with CNT_W=2, five consecutive stalls leave stall_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the per-stage destination tag, the bubble
// value loaded on stalls/flushes, and the architectural zero register index.
package pipe_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwr;
        logic       memrd;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE = '0;
    localparam logic [4:0] XZR    = 5'd31;

endpackage : pipe_pkg

// File: rtl/hazard_tracker_dest_stage.sv
// One pipeline slot holding a destination tag. Squash replaces the incoming
// tag with a bubble; reset clears the slot immediately.
module dest_stage
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       squash,
    input  stage_tag_t d,
    output stage_tag_t q
);

    // Tag register: async clear, otherwise capture (or squash) on load.
    // NOTE: state uses non-blocking (<=) so all stages shift off the same
    // pre-edge values; blocking here would collapse the pipeline in one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= squash ? BUBBLE : d;
        end
    end

endmodule : dest_stage

// File: rtl/hazard_tracker.sv
// Tracks the destination register of the instructions in EX, MEM and WB,
// detects load-use hazards against the decode stage, and counts stall cycles.
module hazard_tracker
    import pipe_pkg::*;
#(
    parameter logic [4:0] XZR   = pipe_pkg::XZR,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rd,
    input  logic             id_regwr,
    input  logic             id_memrd,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             flush,
    output logic [4:0]       dest_ex,
    output logic [4:0]       dest_mem,
    output logic [4:0]       dest_wb,
    output logic             regwr_ex,
    output logic             regwr_mem,
    output logic             regwr_wb,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_tag_t dec_tag;
    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;
    logic       rn_hit;
    logic       rm_hit;
    logic       wb_memrd_unused;

    // Build the decode tag; writes to the zero register are never tracked.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a field unassigned and infers a latch.
    always_comb begin
        dec_tag       = BUBBLE;
        dec_tag.valid = id_valid;
        dec_tag.rd    = id_rd;
        dec_tag.regwr = id_valid & id_regwr & (id_rd != XZR);
        dec_tag.memrd = id_valid & id_memrd;
    end

    // Load-use hazard: a load in EX produces a source the decode stage reads.
    always_comb begin
        rn_hit = id_use_rn & (id_rn == ex_tag.rd) & (id_rn != XZR);
        rm_hit = id_use_rm & (id_rm == ex_tag.rd) & (id_rm != XZR);
        stall  = ex_tag.valid & ex_tag.memrd & ex_tag.regwr & id_valid & (rn_hit | rm_hit);
    end

    // EX takes a bubble on stall or flush; MEM takes a bubble on flush
    // because the EX instruction is on the wrong path.
    dest_stage u_ex (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b1),
        .squash  (stall | flush),
        .d       (dec_tag),
        .q       (ex_tag)
    );

    dest_stage u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b1),
        .squash  (flush),
        .d       (ex_tag),
        .q       (mem_tag)
    );

    dest_stage u_wb (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b1),
        .squash  (1'b0),
        .d       (mem_tag),
        .q       (wb_tag)
    );

    // The load flag has no consumer once the instruction reaches WB.
    assign wb_memrd_unused = wb_tag.memrd;

    // Stage outputs straight from the tag registers, zeroed for empty slots.
    always_comb begin
        dest_ex   = ex_tag.valid  ? ex_tag.rd  : 5'd0;
        dest_mem  = mem_tag.valid ? mem_tag.rd : 5'd0;
        dest_wb   = wb_tag.valid  ? wb_tag.rd  : 5'd0;
        regwr_ex  = ex_tag.valid  & ex_tag.regwr;
        regwr_mem = mem_tag.valid & mem_tag.regwr;
        regwr_wb  = wb_tag.valid  & wb_tag.regwr;
    end

    // Saturating stall counter; a flush overrides the stall, so no count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule : hazard_tracker
